// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-memory responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        STORE,
        BAD
    } op_e;

    localparam int unsigned DEPTH_DEFAULT = 256;
    localparam int unsigned WAIT_DEFAULT  = 2;

    // Load and store together cannot be honoured, so the pair decodes to BAD.
    function automatic op_e decode_op(input logic rd, input logic wr);
        if (rd && wr) begin
            return BAD;
        end
        if (rd) begin
            return LOAD;
        end
        if (wr) begin
            return STORE;
        end
        return NONE;
    endfunction

    function automatic logic addr_in_range(input logic [15:0] addr, input int unsigned depth);
        return {16'd0, addr} < depth;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 16 storage: synchronous write, combinational read, no reset.
module mem_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_wdata,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];

    // Single write port; contents survive reset by design.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches one load/store, inserts WAIT_CYCLES wait
// states, then completes with a one-cycle ready (and err) pulse.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEFAULT,
    parameter int unsigned WAIT_CYCLES = WAIT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_stall,
    output logic        o_ready,
    output logic        o_err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  LAST_CNT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    state_e      r_state;
    state_e      w_state_d;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_d;
    op_e         r_op;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;
    logic        r_ready;
    logic        r_err;

    op_e         w_op;
    logic [15:0] w_addr;
    logic [15:0] w_wdata;
    logic [15:0] w_arr_rdata;
    logic        w_req;
    logic        w_in_range;
    logic        w_enter_done;
    logic        w_we;

    assign w_req = i_mem_rd | i_mem_wr;

    // In IDLE the access comes straight from the inputs so a zero-wait access
    // can complete on the accepting edge; afterwards only latched values count.
    always_comb begin
        if (r_state == IDLE) begin
            w_op    = decode_op(i_mem_rd, i_mem_wr);
            w_addr  = i_addr;
            w_wdata = i_wdata;
        end else begin
            w_op    = r_op;
            w_addr  = r_addr;
            w_wdata = r_wdata;
        end
    end

    assign w_in_range   = addr_in_range(w_addr, DEPTH);
    assign w_enter_done = (w_state_d == DONE) && (r_state != DONE);
    assign w_we         = w_enter_done && (w_op == STORE) && w_in_range;

    // Next-state, wait counter and combinational stall.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        o_stall   = 1'b0;
        unique case (r_state)
            IDLE: begin
                o_stall = w_req;
                if (w_req) begin
                    w_cnt_d   = 3'd0;
                    w_state_d = (WAIT_CYCLES == 0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                o_stall = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_state_d = DONE;
                end else begin
                    w_cnt_d = r_cnt + 3'd1;
                end
            end
            DONE: begin
                w_state_d = IDLE;
                w_cnt_d   = 3'd0;
            end
            default: begin
                w_state_d = IDLE;
                w_cnt_d   = 3'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Request latches: captured on acceptance, operation cleared after completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op    <= NONE;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else if ((r_state == IDLE) && w_req) begin
            r_op    <= w_op;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end else if (r_state == DONE) begin
            r_op <= NONE;
        end
    end

    // Completion outputs; rdata only moves when a load completes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 16'h0000;
        end else begin
            r_ready <= w_enter_done;
            r_err   <= w_enter_done && ((w_op == BAD) || !w_in_range);
            if (w_enter_done && (w_op == LOAD)) begin
                r_rdata <= w_in_range ? w_arr_rdata : 16'h0000;
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_ready = r_ready;
    assign o_err   = r_err;

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_addr  (w_addr[AW-1:0]),
        .i_wdata (w_wdata),
        .o_rdata (w_arr_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT 2, 0, 3) driven by
// directed and random accesses, checked against an array-based memory model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;

    logic             clk;
    logic [2:0]       rst_n;
    logic [2:0]       rd;
    logic [2:0]       wr;
    logic [2:0][15:0] addr_v;
    logic [2:0][15:0] wdata_v;
    logic [2:0][15:0] rdata_v;
    logic [2:0]       stall;
    logic [2:0]       ready;
    logic [2:0]       err;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: word array, known flags, last load result.
    logic [15:0] m_mem [3][256];
    bit          m_known [3][256];
    logic [15:0] m_rd [3];
    bit          m_rdk [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH       (DEPTH),
            .WAIT_CYCLES ((g == 0) ? 2 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n[g]),
            .i_mem_rd(rd[g]),
            .i_mem_wr(wr[g]),
            .i_addr  (addr_v[g]),
            .i_wdata (wdata_v[g]),
            .o_rdata (rdata_v[g]),
            .o_stall (stall[g]),
            .o_ready (ready[g]),
            .o_err   (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 0 : 3);
    endfunction

    // Applies one access to the model and returns what the DUT should report.
    task automatic model_access(input int d, input bit op_rd, input bit op_wr,
                                input logic [15:0] a, input logic [15:0] wd,
                                output bit e_err, output logic [15:0] e_rdata,
                                output bit e_known);
        e_err = (op_rd && op_wr) || (int'(a) >= int'(DEPTH));
        if (!e_err && op_wr) begin
            m_mem[d][a[7:0]]   = wd;
            m_known[d][a[7:0]] = 1'b1;
        end
        if (op_rd && !op_wr) begin
            if (e_err) begin
                m_rd[d]  = 16'h0000;
                m_rdk[d] = 1'b1;
            end else begin
                m_rd[d]  = m_mem[d][a[7:0]];
                m_rdk[d] = m_known[d][a[7:0]];
            end
        end
        e_rdata = m_rd[d];
        e_known = m_rdk[d];
    endtask

    // Drives one request starting at a negedge and records what was observed.
    // Returns at a negedge. With hold set the request stays asserted.
    task automatic do_access(input int d, input bit op_rd, input bit op_wr,
                             input logic [15:0] a, input logic [15:0] wd,
                             input bit hold, input bit chg,
                             input logic [15:0] ca, input logic [15:0] cw,
                             output int lat, output int st_hi,
                             output logic d_stall, output logic d_err,
                             output logic [15:0] d_rdata,
                             output logic n_ready, output logic n_stall);
        rd[d]      = op_rd;
        wr[d]      = op_wr;
        addr_v[d]  = a;
        wdata_v[d] = wd;
        #1;
        st_hi = stall[d] ? 1 : 0;
        lat   = 0;
        while (lat < 16) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ready[d]) break;
            if (stall[d]) st_hi++;
            if (chg && lat == 1) begin
                addr_v[d]  = ca;
                wdata_v[d] = cw;
            end
        end
        d_stall = stall[d];
        d_err   = err[d];
        d_rdata = rdata_v[d];
        @(posedge clk);
        #1;
        if (!hold) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
        end
        @(negedge clk);
        n_ready = ready[d];
        n_stall = stall[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if ({rdata_v[d], ready[d], err[d], stall[d]} !== 19'h0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got rdata=%h rdy=%b err=%b stall=%b want all 0",
                         d, rdata_v[d], ready[d], err[d], stall[d]);
            end
        end
    endtask

    task automatic test_store_load_w2();
        int lat, sh;
        logic ds, de, nr, ns;
        logic [15:0] dr, er;
        bit ee, ek;
        model_access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, ee, er, ek);
        do_access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL w2_store_latency: got %0d want 3", lat);
        end
        n_chk++;
        if (sh !== 3) begin
            n_fail++; $display("FAIL w2_store_stall_cycles: got %0d want 3", sh);
        end
        n_chk++;
        if ({ds, de, nr} !== 3'b000) begin
            n_fail++; $display("FAIL w2_store_done: got stall=%b err=%b next_ready=%b want 000",
                               ds, de, nr);
        end
        model_access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, ee, er, ek);
        do_access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (dr !== 16'hBEEF || de !== 1'b0) begin
            n_fail++; $display("FAIL w2_load: got rdata=%h err=%b want BEEF 0", dr, de);
        end
        n_chk++;
        if (lat !== 3) begin
            n_fail++; $display("FAIL w2_load_latency: got %0d want 3", lat);
        end
    endtask

    task automatic test_wait0();
        int lat, sh;
        logic ds, de, nr, ns;
        logic [15:0] dr, er;
        bit ee, ek;
        model_access(1, 1'b0, 1'b1, 16'h0003, 16'h1234, ee, er, ek);
        do_access(1, 1'b0, 1'b1, 16'h0003, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (lat !== 1 || de !== 1'b0) begin
            n_fail++; $display("FAIL w0_store: got lat=%0d err=%b want 1 0", lat, de);
        end
        model_access(1, 1'b1, 1'b0, 16'h0003, 16'h0000, ee, er, ek);
        do_access(1, 1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (lat !== 1) begin
            n_fail++; $display("FAIL w0_load_latency: got %0d want 1", lat);
        end
        n_chk++;
        if (ds !== 1'b0 || sh !== 1) begin
            n_fail++; $display("FAIL w0_stall: got done_stall=%b stall_cycles=%0d want 0 1",
                               ds, sh);
        end
        n_chk++;
        if (dr !== 16'h1234) begin
            n_fail++; $display("FAIL w0_load_data: got %h want 1234", dr);
        end
    endtask

    task automatic test_out_of_range();
        int lat, sh;
        logic ds, de, nr, ns;
        logic [15:0] dr, er;
        bit ee, ek;
        model_access(0, 1'b0, 1'b1, 16'h0000, 16'h5A5A, ee, er, ek);
        do_access(0, 1'b0, 1'b1, 16'h0000, 16'h5A5A, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        model_access(0, 1'b0, 1'b1, 16'h0100, 16'hFFFF, ee, er, ek);
        do_access(0, 1'b0, 1'b1, 16'h0100, 16'hFFFF, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (de !== 1'b1 || lat !== 3) begin
            n_fail++; $display("FAIL oor_store: got err=%b lat=%0d want 1 3", de, lat);
        end
        model_access(0, 1'b1, 1'b0, 16'h0100, 16'h0000, ee, er, ek);
        do_access(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (de !== 1'b1 || dr !== 16'h0000) begin
            n_fail++; $display("FAIL oor_load: got err=%b rdata=%h want 1 0000", de, dr);
        end
        model_access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, ee, er, ek);
        do_access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (dr !== er || de !== 1'b0) begin
            n_fail++; $display("FAIL oor_no_alias: got rdata=%h err=%b want %h 0", dr, de, er);
        end
    endtask

    task automatic test_both_ops();
        int lat, sh;
        logic ds, de, nr, ns;
        logic [15:0] dr, er;
        bit ee, ek;
        model_access(0, 1'b0, 1'b1, 16'h0005, 16'h1111, ee, er, ek);
        do_access(0, 1'b0, 1'b1, 16'h0005, 16'h1111, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        model_access(0, 1'b1, 1'b1, 16'h0005, 16'h2222, ee, er, ek);
        do_access(0, 1'b1, 1'b1, 16'h0005, 16'h2222, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (de !== 1'b1 || lat !== 3) begin
            n_fail++; $display("FAIL both_err: got err=%b lat=%0d want 1 3", de, lat);
        end
        n_chk++;
        if (dr !== er) begin
            n_fail++; $display("FAIL both_rdata_kept: got %h want %h", dr, er);
        end
        model_access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, ee, er, ek);
        do_access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (dr !== 16'h1111) begin
            n_fail++; $display("FAIL both_no_write: got %h want 1111", dr);
        end
    endtask

    task automatic test_midbusy_change();
        int lat, sh;
        logic ds, de, nr, ns;
        logic [15:0] dr, er;
        bit ee, ek;
        model_access(2, 1'b0, 1'b1, 16'h0031, 16'h0F0F, ee, er, ek);
        do_access(2, 1'b0, 1'b1, 16'h0031, 16'h0F0F, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        model_access(2, 1'b0, 1'b1, 16'h0030, 16'h1357, ee, er, ek);
        do_access(2, 1'b0, 1'b1, 16'h0030, 16'h1357, 1'b0, 1'b1, 16'h0031, 16'h9999,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (lat !== 4 || de !== 1'b0) begin
            n_fail++; $display("FAIL midbusy_store: got lat=%0d err=%b want 4 0", lat, de);
        end
        model_access(2, 1'b1, 1'b0, 16'h0030, 16'h0000, ee, er, ek);
        do_access(2, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (dr !== 16'h1357) begin
            n_fail++; $display("FAIL midbusy_latched_data: got %h want 1357", dr);
        end
        model_access(2, 1'b1, 1'b0, 16'h0031, 16'h0000, ee, er, ek);
        do_access(2, 1'b1, 1'b0, 16'h0031, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (dr !== 16'h0F0F) begin
            n_fail++; $display("FAIL midbusy_other_addr: got %h want 0F0F", dr);
        end
    endtask

    task automatic test_reset_abort();
        int lat, sh;
        logic ds, de, nr, ns;
        logic [15:0] dr, er;
        bit ee, ek;
        bit saw_ready;
        model_access(2, 1'b0, 1'b1, 16'h0020, 16'h5555, ee, er, ek);
        do_access(2, 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        // Store of AAAA that gets aborted; the model never sees it.
        wr[2]      = 1'b1;
        addr_v[2]  = 16'h0020;
        wdata_v[2] = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        n_chk++;
        if (stall[2] !== 1'b1) begin
            n_fail++; $display("FAIL abort_busy_stall: got %b want 1", stall[2]);
        end
        @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        wr[2]    = 1'b0;
        #1;
        n_chk++;
        if ({stall[2], ready[2], err[2], rdata_v[2]} !== 19'h0) begin
            n_fail++; $display("FAIL abort_reset_outputs: got stall=%b rdy=%b err=%b rdata=%h want 0",
                               stall[2], ready[2], err[2], rdata_v[2]);
        end
        m_rd[2]  = 16'h0000;
        m_rdk[2] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[2]  = 1'b1;
        saw_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ready[2]) saw_ready = 1'b1;
        end
        n_chk++;
        if (saw_ready !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_completion: got ready=1 want 0");
        end
        model_access(2, 1'b1, 1'b0, 16'h0020, 16'h0000, ee, er, ek);
        do_access(2, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (dr !== 16'h5555) begin
            n_fail++; $display("FAIL abort_no_write: got %h want 5555", dr);
        end
    endtask

    task automatic test_back_to_back();
        int lat, sh;
        logic ds, de, nr, ns;
        logic [15:0] dr, er;
        bit ee, ek;
        model_access(1, 1'b0, 1'b1, 16'h0040, 16'h0A0A, ee, er, ek);
        do_access(1, 1'b0, 1'b1, 16'h0040, 16'h0A0A, 1'b1, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (nr !== 1'b0 || ns !== 1'b1) begin
            n_fail++; $display("FAIL b2b_after_done: got ready=%b stall=%b want 0 1", nr, ns);
        end
        model_access(1, 1'b1, 1'b0, 16'h0040, 16'h0000, ee, er, ek);
        do_access(1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0,
                  lat, sh, ds, de, dr, nr, ns);
        n_chk++;
        if (lat !== 1 || dr !== 16'h0A0A) begin
            n_fail++; $display("FAIL b2b_second: got lat=%0d rdata=%h want 1 0A0A", lat, dr);
        end
    endtask

    task automatic test_random();
        int lat, sh, w, sel;
        logic ds, de, nr, ns;
        logic [15:0] dr, er, a, wd;
        bit ee, ek, hold, o_rd, o_wr;
        for (int d = 0; d < 3; d++) begin
            w = wait_of(d);
            for (int i = 0; i < 30; i++) begin
                sel  = int'($urandom_range(0, 5));
                o_wr = (sel <= 2) || (sel == 5);
                o_rd = (sel >= 3);
                a    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(256, 65535))
                                                   : 16'($urandom_range(0, 31));
                wd   = 16'($urandom);
                hold = (i != 29) && ($urandom_range(0, 3) == 0);
                model_access(d, o_rd, o_wr, a, wd, ee, er, ek);
                do_access(d, o_rd, o_wr, a, wd, hold, 1'b0, 16'h0, 16'h0,
                          lat, sh, ds, de, dr, nr, ns);
                n_chk++;
                if (lat !== w + 1 || sh !== w + 1) begin
                    n_fail++; $display("FAIL rnd_timing[%0d.%0d]: got lat=%0d stall=%0d want %0d",
                                       d, i, lat, sh, w + 1);
                end
                n_chk++;
                if (de !== ee || ds !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_err[%0d.%0d]: got err=%b stall=%b want %b 0",
                                       d, i, de, ds, ee);
                end
                if (ek) begin
                    n_chk++;
                    if (dr !== er) begin
                        n_fail++; $display("FAIL rnd_rdata[%0d.%0d] addr %h: got %h want %h",
                                           d, i, a, dr, er);
                    end
                end
                n_chk++;
                if (nr !== 1'b0 || ns !== hold) begin
                    n_fail++; $display("FAIL rnd_after[%0d.%0d]: got ready=%b stall=%b want 0 %b",
                                       d, i, nr, ns, hold);
                end
            end
        end
    endtask

    initial begin
        rst_n   = 3'b111;
        rd      = 3'b000;
        wr      = 3'b000;
        addr_v  = '0;
        wdata_v = '0;
        for (int d = 0; d < 3; d++) begin
            m_rd[d]  = 16'h0000;
            m_rdk[d] = 1'b1;
            for (int k = 0; k < 256; k++) begin
                m_known[d][k] = 1'b0;
                m_mem[d][k]   = 16'h0000;
            end
        end
        #1;
        rst_n = 3'b000;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 3'b111;
        @(negedge clk);
        test_store_load_w2();
        test_wait0();
        test_out_of_range();
        test_both_ops();
        test_midbusy_change();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of 16-bit data-memory words (power of two, 2..65536).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the access wait states inserted before completion (range 0..7).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  the reset: asynchronous, active-low.
REQ-005 The block SHALL have port mem_rd  input  1  load request from the datapath.
REQ-006 The block SHALL have port mem_wr  input  1  store request (write_to_mem).
REQ-007 The block SHALL have port addr  input  16  word address (the ALU result).
REQ-008 The block SHALL have port wdata  input  16  store data (register-file second read port).
REQ-009 The block SHALL have port rdata  output  16  load data (RD), registered.
REQ-010 The block SHALL have port stall  output  1  freeze the pipeline while an access is outstanding.
REQ-011 The block SHALL have port ready  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port err  output  1  one-cycle error pulse, coincident with ready.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-014 In IDLE, on a clock edge with mem_rd or mem_wr high, the block SHALL latch addr, wdata and the operation, then go to BUSY (WAIT_CYCLES>0) or DONE (WAIT_CYCLES=0).
REQ-015 In BUSY, a 3-bit counter SHALL count WAIT_CYCLES edges, then the FSM SHALL go to DONE.
REQ-016 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE; no request is accepted in DONE.
REQ-017 stall SHALL be combinational: high in BUSY, and high in IDLE while mem_rd or mem_wr is high; low in DONE.
REQ-018 ready SHALL be high exactly while the FSM is in DONE; request-to-ready latency SHALL be WAIT_CYCLES+1 edges.
REQ-019 A store SHALL write the latched wdata to the latched address on the edge entering DONE.
REQ-020 A load SHALL register array[latched address] into rdata on the edge entering DONE; rdata SHALL hold until the next load completes.
REQ-021 If latched addr >= DEPTH, the block SHALL raise err with ready, suppress any write, and load 16'h0000 into rdata for a load.
REQ-022 If mem_rd and mem_wr are both high when sampled in IDLE, the block SHALL treat the access as an error: no write, rdata unchanged, err with ready.
REQ-023 Inputs changing during BUSY SHALL be ignored; only latched values are used.
REQ-024 The requester SHALL hold the request through DONE; a request still high in the cycle after DONE SHALL be accepted as a new access.

Reset
REQ-025 On rst low, the block SHALL immediately set: state IDLE, counter 0, rdata 16'h0000, ready 0, err 0, latched operation none.
REQ-026 A reset asserted before the edge entering DONE SHALL abort the access; an aborted store SHALL NOT modify the array.
REQ-027 The memory array contents SHALL NOT be reset.

Structure
REQ-028 Shared package data_mem_pkg SHALL hold the state enumeration (IDLE, BUSY, DONE), DEPTH_DEFAULT=256, WAIT_DEFAULT=2 and the operation encoding (NONE, LOAD, STORE, BAD).
REQ-029 The storage SHALL be one sub-module, mem_array: synchronous write, combinational read, DEPTH x 16, with no reset.
REQ-030 The FSM, counter, latches and output registers SHALL live in data_mem_responder.

Verification
REQ-031 Bench: WAIT=2; store addr 0x0010 data 0xBEEF -> stall high 3 cycles, ready 1 cycle; then load 0x0010 -> rdata 0xBEEF with ready, err 0.
REQ-032 Bench: WAIT=0; load addr 0x0003 after a store of 0x1234 -> ready on first edge, stall low in DONE, rdata 0x1234.
REQ-033 Bench: DEPTH=256; store 0x0100 data 0xFFFF, then load 0x0100 -> err=1 with ready both times, rdata 0x0000, array[0x00] unchanged.
REQ-034 Bench: mem_rd=mem_wr=1 at addr 0x0005 -> err with ready, array[0x0005] and rdata unchanged.
REQ-035 Bench: WAIT=3; store 0x0020 data 0xAAAA, rst low during BUSY -> immediate IDLE, stall low, ready 0; later load 0x0020 returns the prior value.
REQ-036 Bench: change addr/wdata mid-BUSY -> the originally latched address and data are used.
